// File: rtl/data_sram_arbiter.sv
// Merges two data-side SRAM-like masters onto one slave port; addr_ok and data_ok are combinational (0 cycles).
// A refused request locks the grant so the slave sees stable req/addr; at MAX_OUTSTANDING in flight no request is presented.
module data_sram_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    output logic        idle
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_OUTSTANDING);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          lock_vld_q, lock_vld_d;
    logic          lock_id_q, lock_id_d;
    logic          id_q [MAX_OUTSTANDING];
    logic          id_d [MAX_OUTSTANDING];

    logic gnt, gnt_req, full, empty, accept, pop, head;

    always_comb begin
        // gnt: 0 selects m0 (d1), 1 selects m1 (d2)
        gnt     = lock_vld_q ? lock_id_q : !m0_req;
        gnt_req = gnt ? m1_req : m0_req;
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        s_req   = gnt_req && !full;
        s_wr    = gnt ? m1_wr    : m0_wr;
        s_size  = gnt ? m1_size  : m0_size;
        s_wstrb = gnt ? m1_wstrb : m0_wstrb;
        s_addr  = gnt ? m1_addr  : m0_addr;
        s_wdata = gnt ? m1_wdata : m0_wdata;
        accept  = s_req && s_addr_ok;
        m0_addr_ok = accept && !gnt;
        m1_addr_ok = accept && gnt;
        head    = id_q[rd_ptr_q];
        pop     = s_data_ok && !empty;
        m0_data_ok = pop && !head;
        m1_data_ok = pop && head;
        m0_rdata   = (!empty && !head) ? s_rdata : '0;
        m1_rdata   = (!empty && head)  ? s_rdata : '0;
        idle       = empty && !m0_req && !m1_req;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(accept);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW+1)'(accept) - (PW+1)'(pop);
        id_d     = id_q;
        if (accept) begin
            id_d[wr_ptr_q] = gnt;
        end
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        // Hold the grant on a refused request; release once it is taken or withdrawn.
        if (accept || !gnt_req) begin
            lock_vld_d = 1'b0;
        end else if (s_req) begin
            lock_vld_d = 1'b1;
            lock_id_d  = gnt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            id_q       <= id_d;
        end
    end

`ifdef DATA_SRAM_ARB_PROTO_CHECK
    // A response with nothing outstanding is a slave protocol violation.
    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn) !(s_data_ok && empty));
`endif

endmodule
